// File: rtl/t09_lcd_pkg.sv
// t09_lcd_pkg
// Shared definitions for the LCD command sequencer:
//   - ILI9341-class opcodes and the RGB565 pixel-format argument
//   - init ROM entry type and the init ROM itself
//   - sequencer state enum and transaction kind
package t09_lcd_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] PIXFMT_565 = 8'h55;

  localparam int INIT_LEN = 5;
  localparam int HDR_LEN  = 11;

  // Which power-up delay (if any) follows an init byte
  typedef enum logic [1:0] {
    DLY_NONE,
    DLY_RST,
    DLY_SLP
  } dly_sel_e;

  typedef struct packed {
    logic     is_data;
    logic [7:0] data_byte;
    dly_sel_e delay_sel;
  } init_entry_t;

  localparam init_entry_t INIT_ROM [INIT_LEN] = '{
    '{1'b0, OP_SWRESET, DLY_RST},
    '{1'b0, OP_SLPOUT,  DLY_SLP},
    '{1'b0, OP_COLMOD,  DLY_NONE},
    '{1'b1, PIXFMT_565, DLY_NONE},
    '{1'b0, OP_DISPON,  DLY_NONE}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } seq_state_e;

  typedef enum logic {
    TXN_INIT,
    TXN_UPDATE
  } txn_kind_e;

endpackage

// File: rtl/t09_lcd_byte_writer.sv
// t09_lcd_byte_writer
// Two-phase 8080 write strobe generator. A byte accepted on start_i is
// driven for two cycles: phase 0 with wr_n low, phase 1 with wr_n high.
// Data and dcx are held steady across both phases (and afterwards).
// Ports:
//   clk, nrst  : clock, async active-low reset
//   start_i    : launch a byte (honoured only while ready_o is high)
//   byte_i     : byte to write
//   dcx_i      : 0 = command, 1 = data
//   ready_o    : high in idle and in phase 1, so bytes can run back-to-back
//   wr_n_o, dcx_o, data_o : registered LCD bus outputs
module t09_lcd_byte_writer (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dcx_i,
  output logic       ready_o,
  output logic       wr_n_o,
  output logic       dcx_o,
  output logic [7:0] data_o
);

  logic       wr_n_q, wr_n_d;
  logic       dcx_q, dcx_d;
  logic [7:0] data_q, data_d;

  // wr_n low marks phase 0; any other cycle can launch the next byte,
  // which lets phase 1 of one byte abut phase 0 of the next.
  assign ready_o = wr_n_q;

  // Next-state: launch a new byte, or finish phase 0 by raising wr_n
  always_comb begin
    wr_n_d = wr_n_q;
    dcx_d  = dcx_q;
    data_d = data_q;
    if (start_i && wr_n_q) begin
      wr_n_d = 1'b0;
      dcx_d  = dcx_i;
      data_d = byte_i;
    end else if (!wr_n_q) begin
      wr_n_d = 1'b1;
    end
  end

  // Bus registers; reset leaves the bus idle with dcx high and data zero
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_n_q <= 1'b1;
      dcx_q  <= 1'b1;
      data_q <= 8'h00;
    end else begin
      wr_n_q <= wr_n_d;
      dcx_q  <= dcx_d;
      data_q <= data_d;
    end
  end

  assign wr_n_o = wr_n_q;
  assign dcx_o  = dcx_q;
  assign data_o = data_q;

endmodule

// File: rtl/t09_lcd_cmd_sequencer.sv
// t09_lcd_cmd_sequencer
// Responder between the game FSM and an 8080-style LCD bus. Runs the
// power-up init sequence or paints one CELL_PX x CELL_PX cell, then
// pulses cmd_done for one cycle.
// Ports:
//   clk, nrst             : clock, async active-low reset
//   init_cycle, en_update : level requests (init has priority)
//   cell_x, cell_y, color : cell position and RGB565 colour, latched on accept
//   cmd_done              : one-cycle completion pulse
//   busy                  : transaction in progress
//   lcd_cs_n, lcd_wr_n, lcd_dcx, lcd_data : LCD bus
module t09_lcd_cmd_sequencer #(
  parameter int CELL_PX     = 10,
  parameter int RST_DLY_CYC = 1_200_000,
  parameter int SLP_DLY_CYC = 1_200_000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        init_cycle,
  input  logic        en_update,
  input  logic [4:0]  cell_x,
  input  logic [4:0]  cell_y,
  input  logic [15:0] color,
  output logic        cmd_done,
  output logic        busy,
  output logic        lcd_cs_n,
  output logic        lcd_wr_n,
  output logic        lcd_dcx,
  output logic [7:0]  lcd_data
);

  import t09_lcd_pkg::*;

  localparam logic [8:0]  NPIX    = 9'(CELL_PX * CELL_PX);
  localparam logic [15:0] PX16    = 16'(CELL_PX);
  localparam logic [23:0] RST_DLY = 24'(RST_DLY_CYC);
  localparam logic [23:0] SLP_DLY = 24'(SLP_DLY_CYC);

  seq_state_e  state_q;
  txn_kind_e   kind_q;
  logic [3:0]  idx_q;
  logic [8:0]  pix_q;
  logic        lo_q;
  logic [23:0] dly_q;
  dly_sel_e    pend_q;
  logic [4:0]  cx_q, cy_q;
  logic [15:0] col_q;
  logic        busy_q, cs_n_q, done_q;

  logic [15:0] xs, xe, ys, ye;
  logic        have_next, nxt_dcx, wait_needed;
  logic [7:0]  nxt_byte;
  logic [3:0]  idx_adv;
  logic [8:0]  pix_adv;
  logic        lo_adv;
  dly_sel_e    pend_adv;
  logic        wr_start, wr_dcx, wr_ready;
  logic [7:0]  wr_byte;

  function automatic logic [23:0] dly_of(input dly_sel_e sel);
    case (sel)
      DLY_RST: dly_of = RST_DLY;
      DLY_SLP: dly_of = SLP_DLY;
      default: dly_of = 24'd0;
    endcase
  endfunction

  // Header byte i of an UPDATE as {dcx, byte}
  function automatic logic [8:0] hdr_entry(input logic [3:0] i,
                                           input logic [15:0] x0, input logic [15:0] x1,
                                           input logic [15:0] y0, input logic [15:0] y1);
    case (i)
      4'd0:    hdr_entry = {1'b0, OP_CASET};
      4'd1:    hdr_entry = {1'b1, x0[15:8]};
      4'd2:    hdr_entry = {1'b1, x0[7:0]};
      4'd3:    hdr_entry = {1'b1, x1[15:8]};
      4'd4:    hdr_entry = {1'b1, x1[7:0]};
      4'd5:    hdr_entry = {1'b0, OP_PASET};
      4'd6:    hdr_entry = {1'b1, y0[15:8]};
      4'd7:    hdr_entry = {1'b1, y0[7:0]};
      4'd8:    hdr_entry = {1'b1, y1[15:8]};
      4'd9:    hdr_entry = {1'b1, y1[7:0]};
      default: hdr_entry = {1'b0, OP_RAMWR};
    endcase
  endfunction

  // Next byte of the current list, and the counter values after issuing it.
  // idx_q/pix_q/lo_q always point at the byte still to be sent.
  always_comb begin
    xs = 16'(cx_q) * PX16;
    xe = xs + PX16 - 16'd1;
    ys = 16'(cy_q) * PX16;
    ye = ys + PX16 - 16'd1;

    have_next = 1'b0;
    nxt_byte  = 8'h00;
    nxt_dcx   = 1'b1;
    idx_adv   = idx_q;
    pix_adv   = pix_q;
    lo_adv    = lo_q;
    pend_adv  = DLY_NONE;

    if (kind_q == TXN_INIT) begin
      if (idx_q < 4'(INIT_LEN)) begin
        have_next = 1'b1;
        nxt_byte  = INIT_ROM[idx_q[2:0]].data_byte;
        nxt_dcx   = INIT_ROM[idx_q[2:0]].is_data;
        idx_adv   = idx_q + 4'd1;
        pend_adv  = INIT_ROM[idx_q[2:0]].delay_sel;
      end
    end else if (idx_q < 4'(HDR_LEN)) begin
      have_next         = 1'b1;
      {nxt_dcx, nxt_byte} = hdr_entry(idx_q, xs, xe, ys, ye);
      idx_adv           = idx_q + 4'd1;
    end else if (pix_q < NPIX) begin
      have_next = 1'b1;
      nxt_byte  = lo_q ? col_q[7:0] : col_q[15:8];
      nxt_dcx   = 1'b1;
      lo_adv    = ~lo_q;
      pix_adv   = lo_q ? pix_q + 9'd1 : pix_q;
    end

    // A zero-length delay is skipped entirely
    wait_needed = (pend_q != DLY_NONE) && (dly_of(pend_q) != 24'd0);
  end

  // Writer launch. In IDLE/DONE the first byte goes out on the accepting
  // edge itself, so byte i lands in cycles E0+2i and E0+2i+1.
  always_comb begin
    wr_start = 1'b0;
    wr_byte  = nxt_byte;
    wr_dcx   = nxt_dcx;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (init_cycle) begin
          wr_start = 1'b1;
          wr_byte  = INIT_ROM[0].data_byte;
          wr_dcx   = INIT_ROM[0].is_data;
        end else if (en_update) begin
          wr_start = 1'b1;
          wr_byte  = OP_CASET;
          wr_dcx   = 1'b0;
        end
      end
      ST_SEND: wr_start = wr_ready && have_next && !wait_needed;
      ST_WAIT: wr_start = (dly_q == 24'd0) && have_next;
      default: wr_start = 1'b0;
    endcase
  end

  t09_lcd_byte_writer u_writer (
    .clk     (clk),
    .nrst    (nrst),
    .start_i (wr_start),
    .byte_i  (wr_byte),
    .dcx_i   (wr_dcx),
    .ready_o (wr_ready),
    .wr_n_o  (lcd_wr_n),
    .dcx_o   (lcd_dcx),
    .data_o  (lcd_data)
  );

  // Sequencer FSM. DONE samples requests like IDLE so a held request is
  // re-accepted on the edge that ends the cmd_done cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      kind_q  <= TXN_INIT;
      idx_q   <= 4'd0;
      pix_q   <= 9'd0;
      lo_q    <= 1'b0;
      dly_q   <= 24'd0;
      pend_q  <= DLY_NONE;
      cx_q    <= 5'd0;
      cy_q    <= 5'd0;
      col_q   <= 16'd0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (init_cycle) begin
            state_q <= ST_SEND;
            kind_q  <= TXN_INIT;
            idx_q   <= 4'd1;
            pend_q  <= INIT_ROM[0].delay_sel;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
          end else if (en_update) begin
            state_q <= ST_SEND;
            kind_q  <= TXN_UPDATE;
            idx_q   <= 4'd1;
            pix_q   <= 9'd0;
            lo_q    <= 1'b0;
            pend_q  <= DLY_NONE;
            cx_q    <= cell_x;
            cy_q    <= cell_y;
            col_q   <= color;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
          end
        end
        ST_SEND: begin
          if (wr_ready) begin
            if (wait_needed) begin
              state_q <= ST_WAIT;
              dly_q   <= dly_of(pend_q) - 24'd1;
              pend_q  <= DLY_NONE;
            end else if (have_next) begin
              idx_q  <= idx_adv;
              pix_q  <= pix_adv;
              lo_q   <= lo_adv;
              pend_q <= pend_adv;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              cs_n_q  <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (dly_q == 24'd0) begin
            state_q <= ST_SEND;
            idx_q   <= idx_adv;
            pix_q   <= pix_adv;
            lo_q    <= lo_adv;
            pend_q  <= pend_adv;
          end else begin
            dly_q <= dly_q - 24'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_done = done_q;
  assign busy     = busy_q;
  assign lcd_cs_n = cs_n_q;

endmodule

// File: tb/tb_t09_lcd_cmd_sequencer.sv
// tb_t09_lcd_cmd_sequencer
// Two sequencer instances: A (CELL_PX=10, both delays 4) and B (CELL_PX=16,
// delays 3 and 6). Bytes are captured on each rising lcd_wr_n and compared
// against expected lists built from the byte-list rules.
module tb_t09_lcd_cmd_sequencer;

  localparam int LIMIT = 3000;

  logic        clk = 1'b0;
  logic        nrst;
  logic        initA, updA, initB, updB;
  logic [4:0]  cxA, cyA, cxB, cyB;
  logic [15:0] colA, colB;
  logic        doneA, busyA, csA, wrA, dcxA;
  logic        doneB, busyB, csB, wrB, dcxB;
  logic [7:0]  dataA, dataB;

  logic        selB;
  logic        obsDone, obsBusy, obsCs, obsWr, obsDcx;
  logic [7:0]  obsData;

  logic [8:0]  gotQ[$];
  logic [8:0]  expQ[$];
  int          total = 0;
  int          bad = 0;
  int          doneK;

  typedef struct {
    logic [4:0]  cx;
    logic [4:0]  cy;
    logic [15:0] col;
    logic [15:0] xs;
    logic [15:0] xe;
    logic [15:0] ys;
    logic [15:0] ye;
    int          doneCyc;
  } vec_t;

  vec_t vecs[4];

  t09_lcd_cmd_sequencer #(.CELL_PX(10), .RST_DLY_CYC(4), .SLP_DLY_CYC(4)) dutA (
    .clk(clk), .nrst(nrst), .init_cycle(initA), .en_update(updA),
    .cell_x(cxA), .cell_y(cyA), .color(colA),
    .cmd_done(doneA), .busy(busyA), .lcd_cs_n(csA), .lcd_wr_n(wrA),
    .lcd_dcx(dcxA), .lcd_data(dataA)
  );

  t09_lcd_cmd_sequencer #(.CELL_PX(16), .RST_DLY_CYC(3), .SLP_DLY_CYC(6)) dutB (
    .clk(clk), .nrst(nrst), .init_cycle(initB), .en_update(updB),
    .cell_x(cxB), .cell_y(cyB), .color(colB),
    .cmd_done(doneB), .busy(busyB), .lcd_cs_n(csB), .lcd_wr_n(wrB),
    .lcd_dcx(dcxB), .lcd_data(dataB)
  );

  assign obsDone = selB ? doneB : doneA;
  assign obsBusy = selB ? busyB : busyA;
  assign obsCs   = selB ? csB   : csA;
  assign obsWr   = selB ? wrB   : wrA;
  assign obsDcx  = selB ? dcxB  : dcxA;
  assign obsData = selB ? dataB : dataA;

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case a wait escapes its bound
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic setReq(input logic i, input logic u);
    if (selB) begin
      initB = i;
      updB  = u;
    end else begin
      initA = i;
      updA  = u;
    end
  endtask

  // Drives request and cell inputs at a negedge; accepted on the next posedge
  task automatic applyStimulus(input logic i, input logic u, input logic [4:0] cx,
                               input logic [4:0] cy, input logic [15:0] col);
    if (selB) begin
      cxB = cx; cyB = cy; colB = col;
    end else begin
      cxA = cx; cyA = cy; colA = col;
    end
    setReq(i, u);
  endtask

  // Samples one cycle per negedge after the accepting edge (k=0 is cycle E0),
  // collecting bytes on rising wr_n until cmd_done or the cycle budget.
  task automatic captureTxn(input int dropInitAt, input int dropUpdAt, output int dk);
    logic       prevWr;
    logic [8:0] ph0;
    int         stabErr, csErr;
    gotQ.delete();
    dk      = -1;
    prevWr  = 1'b1;
    ph0     = '0;
    stabErr = 0;
    csErr   = 0;
    for (int k = 0; k < LIMIT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (obsDone === 1'b1) begin
        dk = k;
        checkOutput("csHighAtDone", 32'(obsCs), 32'd1);
        checkOutput("busyAtDone", 32'(obsBusy), 32'd1);
        break;
      end
      if (obsCs !== 1'b0 || obsBusy !== 1'b1) csErr++;
      if (obsWr === 1'b0) begin
        ph0 = {obsDcx, obsData};
      end else if (prevWr === 1'b0) begin
        if (ph0 !== {obsDcx, obsData}) stabErr++;
        gotQ.push_back({obsDcx, obsData});
      end
      prevWr = obsWr;
      if (k == dropInitAt) begin
        if (selB) initB = 1'b0; else initA = 1'b0;
      end
      if (k == dropUpdAt) begin
        if (selB) updB = 1'b0; else updA = 1'b0;
      end
    end
    checkOutput("csLowBusyHighInTxn", 32'(csErr), 32'd0);
    checkOutput("byteStableBothPhases", 32'(stabErr), 32'd0);
  endtask

  task automatic expectIdle(input string name);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "BusyLow"}, 32'(obsBusy), 32'd0);
    checkOutput({name, "CsHigh"}, 32'(obsCs), 32'd1);
  endtask

  // Reference: init list
  function automatic void modelInit();
    expQ.delete();
    expQ.push_back(9'h001);
    expQ.push_back(9'h011);
    expQ.push_back(9'h03A);
    expQ.push_back(9'h155);
    expQ.push_back(9'h029);
  endfunction

  // Reference: update list from cell position arithmetic
  function automatic void modelUpdate(input int cx, input int cy, input logic [15:0] col, input int px);
    logic [15:0] x0, x1, y0, y1;
    x0 = 16'(cx * px);
    x1 = 16'(cx * px + px - 1);
    y0 = 16'(cy * px);
    y1 = 16'(cy * px + px - 1);
    expQ.delete();
    expQ.push_back(9'h02A);
    expQ.push_back({1'b1, x0[15:8]}); expQ.push_back({1'b1, x0[7:0]});
    expQ.push_back({1'b1, x1[15:8]}); expQ.push_back({1'b1, x1[7:0]});
    expQ.push_back(9'h02B);
    expQ.push_back({1'b1, y0[15:8]}); expQ.push_back({1'b1, y0[7:0]});
    expQ.push_back({1'b1, y1[15:8]}); expQ.push_back({1'b1, y1[7:0]});
    expQ.push_back(9'h02C);
    for (int p = 0; p < px * px; p++) begin
      expQ.push_back({1'b1, col[15:8]});
      expQ.push_back({1'b1, col[7:0]});
    end
  endfunction

  task automatic compareQueues(input string name);
    int mism;
    int n;
    mism = 0;
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    checkOutput({name, "Len"}, 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < n; i++) begin
      if (gotQ[i] !== expQ[i]) begin
        if (mism == 0)
          $display("[TB] %s first difference at byte %0d got=%h exp=%h", name, i, gotQ[i], expQ[i]);
        mism++;
      end
    end
    checkOutput({name, "Bytes"}, 32'(mism), 32'd0);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "Done"}, 32'(doneA), 32'd0);
    checkOutput({name, "Busy"}, 32'(busyA), 32'd0);
    checkOutput({name, "CsN"}, 32'(csA), 32'd1);
    checkOutput({name, "WrN"}, 32'(wrA), 32'd1);
    checkOutput({name, "Dcx"}, 32'(dcxA), 32'd1);
    checkOutput({name, "Data"}, 32'(dataA), 32'd0);
  endtask

  initial begin
    logic [8:0]  hdr[11];
    logic [8:0]  expPix;
    logic [4:0]  rx, ry;
    logic [15:0] rc;
    int          pixErr, quiet;

    vecs[0] = '{5'd3,  5'd2,  16'hF800, 16'h001E, 16'h0027, 16'h0014, 16'h001D, 422};
    vecs[1] = '{5'd0,  5'd0,  16'h001F, 16'h0000, 16'h0009, 16'h0000, 16'h0009, 422};
    vecs[2] = '{5'd31, 5'd31, 16'hFFFF, 16'h0136, 16'h013F, 16'h0136, 16'h013F, 422};
    vecs[3] = '{5'd25, 5'd7,  16'hA5C3, 16'h00FA, 16'h0103, 16'h0046, 16'h004F, 422};

    nrst = 1'b0;
    selB = 1'b0;
    initA = 0; updA = 0; cxA = 0; cyA = 0; colA = 0;
    initB = 0; updB = 0; cxB = 0; cyB = 0; colB = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Init sequence with 4-cycle delays: done at E0+18
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 16'h0000);
    captureTxn(0, 0, doneK);
    modelInit();
    compareQueues("init");
    checkOutput("initDoneCycle", 32'(doneK), 32'd18);
    expectIdle("afterInit");

    // Table-driven cell updates
    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b0, 1'b1, vecs[v].cx, vecs[v].cy, vecs[v].col);
      captureTxn(0, 0, doneK);
      hdr = '{9'h02A,
              {1'b1, vecs[v].xs[15:8]}, {1'b1, vecs[v].xs[7:0]},
              {1'b1, vecs[v].xe[15:8]}, {1'b1, vecs[v].xe[7:0]},
              9'h02B,
              {1'b1, vecs[v].ys[15:8]}, {1'b1, vecs[v].ys[7:0]},
              {1'b1, vecs[v].ye[15:8]}, {1'b1, vecs[v].ye[7:0]},
              9'h02C};
      checkOutput($sformatf("vec%0dLen", v), 32'(gotQ.size()), 32'd211);
      for (int i = 0; i < 11 && i < gotQ.size(); i++)
        checkOutput($sformatf("vec%0dHdr%0d", v, i), 32'(gotQ[i]), 32'(hdr[i]));
      pixErr = 0;
      for (int i = 11; i < gotQ.size(); i++) begin
        expPix = ((i - 11) % 2 == 0) ? {1'b1, vecs[v].col[15:8]} : {1'b1, vecs[v].col[7:0]};
        if (gotQ[i] !== expPix) pixErr++;
      end
      checkOutput($sformatf("vec%0dPixels", v), 32'(pixErr), 32'd0);
      checkOutput($sformatf("vec%0dDoneCycle", v), 32'(doneK), 32'(vecs[v].doneCyc));
      expectIdle($sformatf("vec%0dAfter", v));
    end

    // Both requests together: init first, held update accepted right after cmd_done
    applyStimulus(1'b1, 1'b1, 5'd5, 5'd6, 16'h07E0);
    captureTxn(0, -1, doneK);
    modelInit();
    compareQueues("prioInit");
    checkOutput("prioInitDoneCycle", 32'(doneK), 32'd18);
    captureTxn(-1, 0, doneK);
    modelUpdate(5, 6, 16'h07E0, 10);
    compareQueues("b2bUpd");
    checkOutput("b2bUpdDoneCycle", 32'(doneK), 32'd422);
    expectIdle("afterB2b");

    // Request dropped 20 cycles in: transaction still completes
    applyStimulus(1'b0, 1'b1, 5'd9, 5'd4, 16'h1234);
    captureTxn(-1, 20, doneK);
    modelUpdate(9, 4, 16'h1234, 10);
    compareQueues("dropUpd");
    checkOutput("dropUpdDoneCycle", 32'(doneK), 32'd422);
    expectIdle("afterDrop");

    // Randomised updates on A
    for (int r = 0; r < 5; r++) begin
      rx = 5'($urandom_range(0, 31));
      ry = 5'($urandom_range(0, 31));
      rc = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(1'b0, 1'b1, rx, ry, rc);
      captureTxn(0, 0, doneK);
      modelUpdate(int'(rx), int'(ry), rc, 10);
      compareQueues($sformatf("randA%0d", r));
      checkOutput($sformatf("randA%0dDoneCycle", r), 32'(doneK), 32'(2 * (11 + 2 * 100)));
      expectIdle($sformatf("randA%0dAfter", r));
    end

    // Instance B: unequal delays, largest cell, far corner
    selB = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 16'h0000);
    captureTxn(0, 0, doneK);
    modelInit();
    compareQueues("initB");
    checkOutput("initBDoneCycle", 32'(doneK), 32'(10 + 3 + 6));
    expectIdle("afterInitB");

    applyStimulus(1'b0, 1'b1, 5'd31, 5'd31, 16'h5A5A);
    captureTxn(0, 0, doneK);
    if (gotQ.size() >= 5) begin
      checkOutput("cornerXsHi", 32'(gotQ[1]), 32'h101);
      checkOutput("cornerXsLo", 32'(gotQ[2]), 32'h1F0);
      checkOutput("cornerXeHi", 32'(gotQ[3]), 32'h101);
      checkOutput("cornerXeLo", 32'(gotQ[4]), 32'h1FF);
    end else begin
      checkOutput("cornerHdrLen", 32'(gotQ.size()), 32'd5);
    end
    modelUpdate(31, 31, 16'h5A5A, 16);
    compareQueues("cornerB");
    checkOutput("cornerBDoneCycle", 32'(doneK), 32'(2 * (11 + 2 * 256)));
    expectIdle("afterCornerB");

    for (int r = 0; r < 2; r++) begin
      rx = 5'($urandom_range(0, 31));
      ry = 5'($urandom_range(0, 31));
      rc = 16'($urandom);
      applyStimulus(1'b0, 1'b1, rx, ry, rc);
      captureTxn(0, 0, doneK);
      modelUpdate(int'(rx), int'(ry), rc, 16);
      compareQueues($sformatf("randB%0d", r));
      checkOutput($sformatf("randB%0dDoneCycle", r), 32'(doneK), 32'(2 * (11 + 2 * 256)));
      expectIdle($sformatf("randB%0dAfter", r));
    end

    // Reset in the middle of the pixel stream on A
    selB = 1'b0;
    applyStimulus(1'b0, 1'b1, 5'd2, 5'd3, 16'hBEEF);
    repeat (41) @(negedge clk);
    checkOutput("preResetMidStreamCsLow", 32'(csA), 32'd0);
    setReq(1'b0, 1'b0);
    #2 nrst = 1'b0;
    #1 checkResetOutputs("midReset");
    @(negedge clk);
    nrst = 1'b1;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wrA !== 1'b1 || csA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0) quiet++;
    end
    checkOutput("quietAfterReset", 32'(quiet), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t09_lcd_cmd_sequencer.md
# t09_lcd_cmd_sequencer

Responder side of the game-control handshake: takes the level requests `init_cycle` and `en_update` from the game FSM, drives the byte sequences onto an 8080-style 8-bit parallel LCD bus (ILI9341-class command set), and returns a one-cycle `cmd_done` when each transaction has finished. It sits between the game FSM and the LCD pins, and owns all bus timing and power-up delays.

## Interface
- `CELL_PX`, default 10: cell edge in pixels; legal range 1–16.
- `RST_DLY_CYC`, default 1_200_000: wait after software reset (0x01), in clk cycles.
- `SLP_DLY_CYC`, default 1_200_000: wait after sleep-out (0x11), in clk cycles.
- `clk` in 1: system clock.
- `nrst` in 1: asynchronous, active-low reset.
- `init_cycle` in 1: level request to run the init sequence.
- `en_update` in 1: level request to paint one cell.
- `cell_x` in 5: cell column for an update.
- `cell_y` in 5: cell row for an update.
- `color` in 16: RGB565 fill colour for an update.
- `cmd_done` out 1: one-cycle completion pulse.
- `busy` out 1: a transaction is in progress.
- `lcd_cs_n` out 1: LCD chip select.
- `lcd_wr_n` out 1: LCD write strobe.
- `lcd_dcx` out 1: 0 = command byte, 1 = data byte.
- `lcd_data` out 8: LCD data bus.

## Operation
- States:
  - IDLE
  - SEND: walks byte list
  - WAIT: delay counter
  - DONE
- IDLE:
  - `init_cycle` high → INIT transaction.
  - Otherwise, `en_update` high → UPDATE transaction.
  - `init_cycle` has priority when both are high.
  - `cell_x`, `cell_y` and `color` are latched on the accepting edge.
- INIT byte list: cmd 0x01, WAIT `RST_DLY_CYC`, cmd 0x11, WAIT `SLP_DLY_CYC`, cmd 0x3A, data 0x55, cmd 0x29. That is 5 bytes.
- UPDATE byte list:
  - Coordinates: xs = cell_x·CELL_PX and xe = xs+CELL_PX−1, both 16-bit; ys and ye are computed the same way. No clipping.
  - Sequence: cmd 0x2A, xs[15:8], xs[7:0], xe[15:8], xe[7:0]; cmd 0x2B, ys[15:8], ys[7:0], ye[15:8], ye[7:0]; cmd 0x2C; then CELL_PX² pixels, each sent as color[15:8] then color[7:0].
  - Total bytes B = 11 + 2·CELL_PX² (211 at the default).
- DONE: `cmd_done` is high for one cycle, then the block returns to IDLE.
- A request that drops mid-transaction does not abort it. The transaction completes and `cmd_done` still pulses; the FSM ignores that pulse.
- A request that rises while `busy` is high is not queued. It is sampled in IDLE only.
- Reset mid-transaction: outputs return to their reset values immediately. A partial LCD write is abandoned, and the FSM is responsible for re-requesting init.

## Timing
- Reset values:
  - `cmd_done`=0, `busy`=0
  - `lcd_cs_n`=1, `lcd_wr_n`=1, `lcd_dcx`=1, `lcd_data`=0x00
  - State = IDLE; all counters 0.
- Accepting edge E0: `busy` and `lcd_cs_n`=0 take effect from E0. `lcd_cs_n` stays low through the last byte and rises with `cmd_done`.
- Byte writes:
  - Each byte takes 2 cycles: phase 0 has `lcd_wr_n`=0, phase 1 has `lcd_wr_n`=1.
  - `lcd_data` and `lcd_dcx` are stable across both phases. The LCD latches on the rising `lcd_wr_n`.
  - Byte i of an UPDATE occupies cycles E0+2i and E0+2i+1.
- UPDATE completion: `cmd_done` is high in cycle E0+2B, i.e. E0+422 at the defaults.
- INIT completion: `cmd_done` is high in cycle E0+10+RST_DLY_CYC+SLP_DLY_CYC. Each WAIT starts in the cycle after the preceding byte's phase 1 and lasts exactly its parameter.
- `busy` falls in the cycle after `cmd_done`.
- Back-to-back requests: the earliest next acceptance is the edge ending that cycle. A request held high continuously after `cmd_done` is re-accepted.
- Counter widths:
  - Delay counter: 24 bits.
  - Pixel counter: ≥ 9 bits (CELL_PX² ≤ 256).
  - Byte index: ≥ 4 bits for the header.

## Structure
- Package `t09_lcd_pkg` holds:
  - Opcodes (0x01, 0x11, 0x3A, 0x29, 0x2A, 0x2B, 0x2C) and PIXFMT_565 = 0x55.
  - Init-ROM entry type {is_data, byte, delay_sel}, plus the init ROM constant.
  - The state enum.
- Sub-module `t09_lcd_byte_writer`: 2-phase strobe generator with `start`/`byte`/`dcx` inputs and a `ready` output. The sequencer feeds it one byte per `ready`.

## Test plan
- Reset, then hold `init_cycle` high with RST_DLY_CYC=SLP_DLY_CYC=4 → bytes 01,11,3A,55,29 are seen on rising `lcd_wr_n`, with `lcd_dcx` = 0,0,0,1,0. `cmd_done` is high exactly in cycle E0+18.
- `en_update` with cell (3,2), colour 0xF800, CELL_PX=10 → header 2A 00 1E 00 27 2B 00 14 00 1D 2C, then 100×(F8,00). `cmd_done` is high at E0+422.
- `init_cycle` and `en_update` raised in the same cycle → INIT runs first. With `en_update` held, UPDATE is accepted on the edge after `cmd_done`.
- Drop `en_update` after 20 cycles of an UPDATE → the full 211 bytes are still sent and `cmd_done` still pulses.
- Assert `nrst` low mid-pixel-stream → all outputs are at reset values within the same cycle. After release, no bus activity occurs until a new request.
- Cell (31,31), CELL_PX=16 → xs=0x01F0 and xe=0x01FF, unclipped.
